// File: rtl/sync_debounce_if.sv
// Signal bundle between raw asynchronous inputs and the debounced outputs of sync_debounce.
// Defining SYNC_DEBOUNCE_STICKY_EN adds the clear/sticky pair.
interface sync_debounce_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
`ifdef SYNC_DEBOUNCE_STICKY_EN
  logic                clear;
  logic [CHANNELS-1:0] sticky;
`endif

  modport master (
    output in,
`ifdef SYNC_DEBOUNCE_STICKY_EN
    output clear,
    input  sticky,
`endif
    input  out, rise, fall
  );

  modport slave (
    input  in,
`ifdef SYNC_DEBOUNCE_STICKY_EN
    input  clear,
    output sticky,
`endif
    output out, rise, fall
  );
endinterface

// File: rtl/sync_debounce.sv
// Per-channel N-flop synchroniser followed by a hold-time debounce filter with registered edge pulses.
// Optional feature: define SYNC_DEBOUNCE_STICKY_EN for clearable any-edge sticky flags.
module sync_debounce #(
  parameter int CHANNELS        = 8,
  parameter int SYNC_BITS       = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_VALUE     = 1'b0
) (
  input  logic           clock,
  input  logic           reset_n,
  sync_debounce_if.slave bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_BITS-1:0] chain [CHANNELS];
  logic [CW-1:0]        cnt   [CHANNELS];
  logic [CHANNELS-1:0]  s;
  logic [CHANNELS-1:0]  done;
  logic [CHANNELS-1:0]  out_q;
  logic [CHANNELS-1:0]  rise_q;
  logic [CHANNELS-1:0]  fall_q;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    s    = '0;
    done = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s[c]    = chain[c][SYNC_BITS-1];
      done[c] = (s[c] != out_q[c]) && (cnt[c] == CNT_LAST);
    end
  end

  // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) chain[c] <= {SYNC_BITS{RESET_VALUE}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) chain[c] <= {chain[c][SYNC_BITS-2:0], bus.in[c]};
    end
  end

  // NOTE: the counter array is small and must restart from zero after reset, so it is reset like plain flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
      out_q  <= {CHANNELS{RESET_VALUE}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (s[c] == out_q[c] || done[c]) cnt[c] <= '0;
        else                             cnt[c] <= cnt[c] + 1'b1;
      end
      // A qualifying channel always has s != out, so s alone gives the edge direction.
      out_q  <= out_q ^ done;
      rise_q <= done & s;
      fall_q <= done & ~s;
    end
  end

  assign bus.out  = out_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef SYNC_DEBOUNCE_STICKY_EN
  logic [CHANNELS-1:0] sticky_q;

  // Set has priority over clear so an edge coinciding with clear is never lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sticky_q <= '0;
    else          sticky_q <= (sticky_q & ~{CHANNELS{bus.clear}}) | rise_q | fall_q;
  end

  assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce: directed latency/glitch cases plus random stimulus
// compared every cycle against a delay-line / hold-window reference model.
`timescale 1ns/1ps
module tb_sync_debounce;
  localparam int CH = 8;
  localparam int SB = 2;
  localparam int D  = 16;
  localparam bit RV = 1'b0;
  localparam int LAT = SB + D;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  sync_debounce_if #(.CHANNELS(CH)) bus ();

  sync_debounce #(
    .CHANNELS(CH), .SYNC_BITS(SB), .DEBOUNCE_CYCLES(D), .RESET_VALUE(RV)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: s is the input delayed SB edges; out flips once the last D
  // values of s all disagree with it.
  logic [CH-1:0] m_dly [SB];
  logic [CH-1:0] m_win [D];
  logic [CH-1:0] m_out, m_rise, m_fall, m_sticky, m_s, m_diff;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < SB; i++) m_dly[i] = {CH{RV}};
        for (int i = 0; i < D; i++)  m_win[i] = {CH{RV}};
        m_out = {CH{RV}}; m_rise = '0; m_fall = '0; m_sticky = '0;
      end else begin
        m_s = m_dly[SB-1];
        for (int i = D-1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = m_s;
        m_diff = '1;
        for (int i = 0; i < D; i++) m_diff &= m_win[i] ^ m_out;
`ifdef SYNC_DEBOUNCE_STICKY_EN
        m_sticky = (m_sticky & ~{CH{bus.clear}}) | m_rise | m_fall;
`endif
        m_rise = m_diff & ~m_out;
        m_fall = m_diff & m_out;
        m_out  = m_out ^ m_diff;
        for (int i = SB-1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = bus.in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (mon_en) begin
        check("out", bus.out, m_out);
        check("rise", bus.rise, m_rise);
        check("fall", bus.fall, m_fall);
        check("rise_and_fall", bus.rise & bus.fall, '0);
`ifdef SYNC_DEBOUNCE_STICKY_EN
        check("sticky", bus.sticky, m_sticky);
`endif
      end
    end
  end

  task automatic do_reset(input logic [CH-1:0] v);
    @(negedge clock);
    reset_n = 1'b0;
    bus.in  = v;
`ifdef SYNC_DEBOUNCE_STICKY_EN
    bus.clear = 1'b0;
`endif
    repeat (3) @(negedge clock);
    #1;
    check("rst_out", bus.out, {CH{RV}});
    check("rst_pulses", bus.rise | bus.fall, '0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Called right after driving at a negedge; counts rising edges until the pulse pattern appears.
  task automatic wait_pulse(input string tag, input logic [CH-1:0] er, input logic [CH-1:0] ef,
                            input int exp_lat);
    int k = 0;
    do begin
      @(posedge clock);
      #1;
      k++;
    end while (!(bus.rise === er && bus.fall === ef) && k < 3 * LAT);
    check(tag, k, exp_lat);
  endtask

  task automatic drive(input logic [CH-1:0] v);
    @(negedge clock);
    bus.in = v;
  endtask

  logic [CH-1:0] nv;
  int pmax;

  initial begin
    reset_n = 1'b0;
    bus.in  = '0;
`ifdef SYNC_DEBOUNCE_STICKY_EN
    bus.clear = 1'b0;
`endif
    repeat (2) @(negedge clock);
    mon_en = 1'b1;

    // Reset with all inputs high, then release
    do_reset(8'hFF);
    wait_pulse("reset_release_lat", 8'hFF, 8'h00, LAT);
    @(posedge clock); #1;
    check("reset_release_width", bus.rise, 8'h00);

    // Glitch of D-1 cycles rejected, D-cycle level accepted
    do_reset(8'h00);
    drive(8'h01);
    repeat (D-1) @(negedge clock);
    bus.in = 8'h00;
    repeat (LAT + 5) @(negedge clock);
    #1;
    check("glitch_out", bus.out, 8'h00);
    drive(8'h01);
    wait_pulse("accept_lat", 8'h01, 8'h00, LAT);

    // Bounce on ch3 then settle high
    do_reset(8'h00);
    nv = '0;
    for (int t = 0; t < 6; t++) begin
      nv ^= 8'h08;
      drive(nv);
      repeat (4) @(negedge clock);
    end
    drive(8'h08);
    wait_pulse("bounce_lat", 8'h08, 8'h00, LAT);

    // Simultaneous multi-channel edges
    do_reset(8'h00);
    drive(8'hA5);
    wait_pulse("simul_rise", 8'hA5, 8'h00, LAT);
    repeat (3) @(negedge clock);
    bus.in = 8'h5A;
    wait_pulse("simul_swap", 8'h5A, 8'hA5, LAT);

    // Reset in the middle of qualification
    do_reset(8'h00);
    drive(8'h02);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("midreset_no_rise", bus.rise, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    wait_pulse("midreset_lat", 8'h02, 8'h00, LAT);

`ifdef SYNC_DEBOUNCE_STICKY_EN
    do_reset(8'h00);
    drive(8'h04);
    wait_pulse("stk_rise", 8'h04, 8'h00, LAT);
    @(negedge clock); bus.clear = 1'b1;
    @(negedge clock); bus.clear = 1'b0;
    #1; check("stk_cleared", bus.sticky, 8'h00);
    drive(8'h00);
    wait_pulse("stk_fall", 8'h00, 8'h04, LAT);
    repeat (4) @(negedge clock);
    #1; check("stk_held", bus.sticky, 8'h04);
    drive(8'h04);
    wait_pulse("stk_rise2", 8'h04, 8'h00, LAT);
    bus.clear = 1'b1;
    @(posedge clock); #1;
    check("stk_set_wins", bus.sticky, 8'h04);
    @(posedge clock); #1;
    check("stk_clear_alone", bus.sticky, 8'h00);
    bus.clear = 1'b0;
`endif

    // Random stimulus: alternating glitchy and slow phases with occasional resets
    do_reset(8'h00);
    nv = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      reset_n = ($urandom_range(0, 399) != 0);
      pmax = ((cyc / 500) % 2) ? 40 : 4;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, pmax - 1) == 0) nv[c] = ~nv[c];
      bus.in = nv;
`ifdef SYNC_DEBOUNCE_STICKY_EN
      bus.clear = ($urandom_range(0, 15) == 0);
`endif
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clock);
    #2;

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
